// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_AW_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_SERVICE = 2'd3
    } hz_state_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter used for branch-prediction hit/miss statistics.
module hazard_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit_v2.sv
// Hazard controller: load-use / jr-branch / RAM2 stalls, branch redirect,
// interrupt sequencing and prediction statistics for the 5-stage pipeline.
module hazard_unit_v2
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW  = REG_AW_DEF,
    parameter int unsigned NSRC    = 3,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   irq_i,
    input  logic                   ram2_conflict_i,
    input  logic                   ex_load_i,
    input  logic [REG_AW-1:0]      ex_regdst_i,
    input  logic [NSRC*REG_AW-1:0] id_src_i,
    input  logic [NSRC-1:0]        id_src_vld_i,
    input  logic                   mem_load_i,
    input  logic [REG_AW-1:0]      mem_regdst_i,
    input  logic                   id_isjump_i,
    input  logic                   id_isbranch_i,
    input  logic                   br_taken_i,
    input  logic                   br_pred_i,
    input  logic [DATA_W-1:0]      epc_i,
    output logic [DATA_W-1:0]      epc_o,
    output logic                   stall_pc_o,
    output logic                   stall_if_o,
    output logic                   flush_if_o,
    output logic                   flush_id_o,
    output logic                   flush_ex_o,
    output logic                   jr_o,
    output logic                   prewrong_o,
    output logic                   precorrc_o,
    output logic                   int_o,
    output logic                   irq_ack_o,
    output logic [CNT_W-1:0]       pred_hit_o,
    output logic [CNT_W-1:0]       pred_miss_o
);

    localparam int unsigned     LC_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [LC_W-1:0] LC_LOAD = LC_W'(MEM_LAT - 1);

    hz_state_t       state, state_nx;
    logic [LC_W-1:0] lu_cnt;
    logic [NSRC-1:0] src_match;
    logic            irq_q, irq_rise, epc_capture;
    logic            lu_hit, lu_stall, jrb_stall, stall;

    for (genvar k = 0; k < NSRC; k++) begin : g_cmp
        assign src_match[k] = id_src_vld_i[k] &&
                              (id_src_i[k*REG_AW +: REG_AW] == ex_regdst_i);
    end

    assign lu_hit    = ex_load_i && (|src_match);
    assign lu_stall  = lu_hit || (lu_cnt != '0);
    assign jrb_stall = (id_isjump_i || id_isbranch_i) && mem_load_i &&
                       (id_src_i[REG_AW-1:0] == mem_regdst_i);
    assign stall     = lu_stall || jrb_stall || ram2_conflict_i;
    assign irq_rise  = irq_i && !irq_q;

    // A hit arriving while the counter is still draining does not restart it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lu_cnt <= '0;
        end else if (state == ST_FLUSH) begin
            lu_cnt <= '0;
        end else if (lu_cnt != '0) begin
            lu_cnt <= lu_cnt - LC_W'(1);
        end else if (lu_hit) begin
            lu_cnt <= LC_LOAD;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
            irq_q <= 1'b0;
            epc_o <= '0;
        end else begin
            state <= state_nx;
            irq_q <= irq_i;
            if (epc_capture) begin
                epc_o <= epc_i;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        epc_capture = 1'b0;
        stall_pc_o  = 1'b0;
        stall_if_o  = 1'b0;
        flush_if_o  = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;
        jr_o        = 1'b0;
        prewrong_o  = 1'b0;
        precorrc_o  = 1'b0;
        int_o       = 1'b0;
        irq_ack_o   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (irq_rise) begin
                    if (stall) begin
                        state_nx = ST_PEND;
                    end else begin
                        state_nx    = ST_FLUSH;
                        epc_capture = 1'b1;
                    end
                end
            end
            ST_PEND: begin
                if (!stall) begin
                    state_nx    = ST_FLUSH;
                    epc_capture = 1'b1;
                end
            end
            ST_FLUSH:   state_nx = ST_SERVICE;
            ST_SERVICE: if (!irq_i) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase

        if (state == ST_FLUSH) begin
            int_o      = 1'b1;
            flush_if_o = 1'b1;
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
        end else begin
            stall_pc_o = stall;
            stall_if_o = stall;
            flush_id_o = stall;
            prewrong_o = id_isbranch_i && (br_pred_i ^ br_taken_i) && !stall;
            precorrc_o = id_isbranch_i && (br_pred_i == br_taken_i) && !stall;
            jr_o       = id_isjump_i && !stall;
            flush_if_o = prewrong_o || jr_o;
            irq_ack_o  = (state == ST_SERVICE);
        end

        // Reset forces every control output low even while inputs are active.
        if (RST) begin
            stall_pc_o = 1'b0;
            stall_if_o = 1'b0;
            flush_if_o = 1'b0;
            flush_id_o = 1'b0;
            flush_ex_o = 1'b0;
            jr_o       = 1'b0;
            prewrong_o = 1'b0;
            precorrc_o = 1'b0;
            int_o      = 1'b0;
            irq_ack_o  = 1'b0;
        end
    end

    hazard_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .en    (precorrc_o),
        .count (pred_hit_o)
    );

    hazard_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .en    (prewrong_o),
        .count (pred_miss_o)
    );

endmodule
